// File: rtl/hazard_ctrl_sb.sv
// Pipeline hazard controller: load-use bubbles, long-latency scoreboard,
// taken-branch front-end flush and a sticky stall watchdog.
module hazard_ctrl_sb #(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int FE_FLUSH_DEPTH   = 2,
  parameter int WDOG_CYCLES      = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_ex_valid,
  input  logic                          id_ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0]     id_ex_rd_addr,
  input  logic [REG_ADDR_WIDTH-1:0]     if_id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0]     if_id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0]     if_id_rd_addr,
  input  logic                          if_id_uses_rs1,
  input  logic                          if_id_uses_rs2,
  input  logic                          if_id_writes_rd,
  input  logic                          issue_long,
  input  logic                          wb_long_valid,
  input  logic [REG_ADDR_WIDTH-1:0]     wb_long_rd,
  input  logic                          branch_taken,
  input  logic                          ex_stall,
  output logic                          pc_stall,
  output logic                          if_id_stall,
  output logic                          id_ex_stall,
  output logic                          ex_mem_stall,
  output logic                          mem_wb_stall,
  output logic [FE_FLUSH_DEPTH-1:0]     fe_flush,
  output logic                          id_ex_flush,
  output logic [2**REG_ADDR_WIDTH-1:0]  sb_busy,
  output logic                          hang_err
);

  localparam int NREGS  = 2**REG_ADDR_WIDTH;
  localparam int WDOG_W = $clog2(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [2:0]        BUB_LOAD = 3'(LOAD_USE_BUBBLES - 1);

  logic [NREGS-1:0]  r_busy;
  logic [2:0]        r_bub;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_hang;

  logic              w_load_use;
  logic              w_sb_hit;
  logic              w_bub_active;
  logic              w_sb_set;
  logic              w_any_stall;
  logic [NREGS-1:0]  w_busy_next;

  assign w_load_use = id_ex_valid && id_ex_mem_read && (id_ex_rd_addr != '0) &&
                      ((if_id_uses_rs1 && (if_id_rs1_addr == id_ex_rd_addr)) ||
                       (if_id_uses_rs2 && (if_id_rs2_addr == id_ex_rd_addr)));

  // busy[0] is held at zero, so x0 can never raise a scoreboard hazard
  assign w_sb_hit = (if_id_uses_rs1  && r_busy[if_id_rs1_addr]) ||
                    (if_id_uses_rs2  && r_busy[if_id_rs2_addr]) ||
                    (if_id_writes_rd && r_busy[if_id_rd_addr]);

  assign w_bub_active = (r_bub != 3'd0);
  assign w_sb_set     = issue_long && id_ex_valid && !ex_stall && (id_ex_rd_addr != '0);

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    fe_flush     = '0;
    id_ex_flush  = 1'b0;
    if (!rst) begin
      if (ex_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_stall = 1'b1;
      end else if (branch_taken) begin
        fe_flush    = '1;
        id_ex_flush = 1'b1;
      end else if (w_load_use || w_bub_active || w_sb_hit) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign w_any_stall = pc_stall | if_id_stall | id_ex_stall | ex_mem_stall | mem_wb_stall;

  // Set is applied after clear so a same-cycle issue to a retiring register stays busy
  always_comb begin
    w_busy_next = r_busy;
    if (wb_long_valid) w_busy_next[wb_long_rd] = 1'b0;
    if (w_sb_set)      w_busy_next[id_ex_rd_addr] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_bub  <= 3'd0;
      r_wdog <= '0;
      r_hang <= 1'b0;
    end else begin
      r_busy <= w_busy_next;

      if (ex_stall)          r_bub <= r_bub;
      else if (branch_taken) r_bub <= 3'd0;
      else if (w_bub_active) r_bub <= r_bub - 3'd1;
      else if (w_load_use)   r_bub <= BUB_LOAD;

      // hang_err rises on the edge where the saturating count reaches its maximum
      if (w_any_stall) begin
        if (r_wdog != WDOG_MAX) r_wdog <= r_wdog + 1'b1;
        if (r_wdog >= WDOG_MAX - 1'b1) r_hang <= 1'b1;
      end else begin
        r_wdog <= '0;
      end
    end
  end

  assign sb_busy  = r_busy;
  assign hang_err = r_hang;

endmodule
